// File: rtl/wr_port_arbiter.sv
// wr_port_arbiter: round-robin register-file write-port arbiter with broadcast guard and power-up sweep
module wr_port_arbiter #(
  parameter int unsigned GUARD_CYCLES = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       req_mux3d,
  input  logic       req_rg2,
  input  logic       req_tr,
  input  logic [4:0] code_mux3d,
  input  logic [4:0] code_rg2,
  input  logic [4:0] code_tr,
  input  logic       init_start,
  output logic [1:0] MUX3S,
  output logic       gnt_mux3d,
  output logic       gnt_rg2,
  output logic       gnt_tr,
  output logic       sweep_active,
  output logic [4:0] sweep_code,
  output logic       init_done,
  output logic       bad_code,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SWEEP, GUARD} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, gcnt, gcnt_n, win, p1, p2, mux3s_n;
  logic [2:0] req_v, gnt_q, gnt_n;
  logic [4:0] code_w, code_n;
  logic legal, sweep_n, done_n, bad_n;
  function automatic logic is_legal(input logic [4:0] c);
    return (c >= 5'd1 && c <= 5'd18) || c == 5'd21 || c == 5'd22 || c == 5'd31;
  endfunction
  // Round-robin pick starting at the pointer; the source granted last cycle is masked out
  always_comb begin
    req_v = {req_tr, req_rg2, req_mux3d} & ~gnt_q;
    p1 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    p2 = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
    win = req_v[ptr] ? ptr : req_v[p1] ? p1 : p2;
    code_w = (win == 2'd0) ? code_mux3d : (win == 2'd1) ? code_rg2 : code_tr;
    legal = is_legal(code_w);
  end
  // Next state and next registered outputs
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    gcnt_n = gcnt;
    mux3s_n = 2'd0;
    gnt_n = 3'b000;
    sweep_n = 1'b0;
    code_n = 5'd0;
    done_n = 1'b0;
    bad_n = 1'b0;
    case (state)
      IDLE: begin
        if (init_start) begin
          state_n = SWEEP;
          sweep_n = 1'b1;
          code_n = 5'd1;
          mux3s_n = 2'd1;
        end else if (|req_v) begin
          gnt_n[win] = 1'b1;
          mux3s_n = legal ? win + 2'd1 : 2'd0;
          bad_n = !legal;
          ptr_n = (win == 2'd2) ? 2'd0 : win + 2'd1;
          if (legal && code_w == 5'd31 && GUARD_CYCLES != 0) begin
            state_n = GUARD;
            gcnt_n = 2'(GUARD_CYCLES);
          end
        end
      end
      SWEEP: begin
        if (sweep_code == 5'd22) begin
          state_n = IDLE;
          done_n = 1'b1;
        end else begin
          sweep_n = 1'b1;
          mux3s_n = 2'd1;
          code_n = (sweep_code == 5'd18) ? 5'd21 : sweep_code + 5'd1;
        end
      end
      GUARD: begin
        if (gcnt <= 2'd1) state_n = IDLE;
        else gcnt_n = gcnt - 2'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  // State and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      ptr <= 2'd0;
      gcnt <= 2'd0;
      MUX3S <= 2'd0;
      gnt_q <= 3'b000;
      sweep_active <= 1'b0;
      sweep_code <= 5'd0;
      init_done <= 1'b0;
      bad_code <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      gcnt <= gcnt_n;
      MUX3S <= mux3s_n;
      gnt_q <= gnt_n;
      sweep_active <= sweep_n;
      sweep_code <= code_n;
      init_done <= done_n;
      bad_code <= bad_n;
      busy <= state_n != IDLE;
    end
  end
  assign gnt_mux3d = gnt_q[0];
  assign gnt_rg2 = gnt_q[1];
  assign gnt_tr = gnt_q[2];
endmodule

// File: tb/tb_wr_port_arbiter.sv
// tb_wr_port_arbiter: directed self-checking bench for wr_port_arbiter
module tb_wr_port_arbiter;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic req_mux3d = 1'b0, req_rg2 = 1'b0, req_tr = 1'b0, init_start = 1'b0;
  logic [4:0] code_mux3d = 5'd0, code_rg2 = 5'd0, code_tr = 5'd0;
  logic [1:0] MUX3S;
  logic gnt_mux3d, gnt_rg2, gnt_tr, sweep_active, init_done, bad_code, busy;
  logic [4:0] sweep_code;
  int passed = 0, total = 0;

  wr_port_arbiter #(.GUARD_CYCLES(2)) dut (
    .Clock(Clock), .Reset(Reset),
    .req_mux3d(req_mux3d), .req_rg2(req_rg2), .req_tr(req_tr),
    .code_mux3d(code_mux3d), .code_rg2(code_rg2), .code_tr(code_tr),
    .init_start(init_start), .MUX3S(MUX3S),
    .gnt_mux3d(gnt_mux3d), .gnt_rg2(gnt_rg2), .gnt_tr(gnt_tr),
    .sweep_active(sweep_active), .sweep_code(sweep_code),
    .init_done(init_done), .bad_code(bad_code), .busy(busy)
  );

  always #5 Clock = ~Clock;

  function automatic logic [13:0] outs();
    return {MUX3S, gnt_tr, gnt_rg2, gnt_mux3d, sweep_active, sweep_code, init_done, bad_code, busy};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (outs() !== 14'd0) $display("FAIL reset_idle cycle %0d: outputs %h, required 0", i, outs());
      else passed++;
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] obs, exp;
    req_mux3d = 1'b1; code_mux3d = 5'd3;
    req_rg2 = 1'b1; code_rg2 = 5'd7;
    req_tr = 1'b1; code_tr = 5'd16;
    for (int i = 0; i < 6; i++) begin
      step();
      obs = {MUX3S, gnt_tr, gnt_rg2, gnt_mux3d};
      exp = {2'(i % 3 + 1), 3'(1 << (i % 3))};
      total++;
      if (obs !== exp || bad_code !== 1'b0 || busy !== 1'b0)
        $display("FAIL round_robin grant %0d: {MUX3S,gnt} %b bad %b busy %b, required %b bad 0 busy 0", i, obs, bad_code, busy, exp);
      else passed++;
    end
    req_mux3d = 1'b0; req_rg2 = 1'b0; req_tr = 1'b0;
    step();
    step();
  endtask

  task automatic test_broadcast_guard();
    req_rg2 = 1'b1; code_rg2 = 5'd31;
    req_tr = 1'b1; code_tr = 5'd5;
    step();
    total++;
    if ({MUX3S, gnt_tr, gnt_rg2, gnt_mux3d, busy} !== 6'b10_010_1)
      $display("FAIL broadcast_grant: MUX3S %0d gnt %b%b%b busy %b, required MUX3S 2 gnt_rg2 busy 1", MUX3S, gnt_tr, gnt_rg2, gnt_mux3d, busy);
    else passed++;
    req_rg2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({MUX3S, gnt_tr, gnt_rg2, gnt_mux3d} !== 5'd0)
        $display("FAIL broadcast_guard cycle %0d: MUX3S %0d gnt %b%b%b, required all 0", i, MUX3S, gnt_tr, gnt_rg2, gnt_mux3d);
      else passed++;
    end
    step();
    total++;
    if ({MUX3S, gnt_tr, gnt_rg2, gnt_mux3d} !== 5'b11_100)
      $display("FAIL broadcast_after_guard: MUX3S %0d gnt %b%b%b, required MUX3S 3 gnt_tr", MUX3S, gnt_tr, gnt_rg2, gnt_mux3d);
    else passed++;
    req_tr = 1'b0;
    step();
  endtask

  task automatic test_illegal_code();
    req_rg2 = 1'b1; code_rg2 = 5'd2;
    step();
    total++;
    if ({MUX3S, gnt_tr, gnt_rg2, gnt_mux3d} !== 5'b10_010)
      $display("FAIL illegal_setup_rg2: MUX3S %0d gnt %b%b%b, required MUX3S 2 gnt_rg2", MUX3S, gnt_tr, gnt_rg2, gnt_mux3d);
    else passed++;
    req_rg2 = 1'b0;
    req_tr = 1'b1; code_tr = 5'd20;
    req_mux3d = 1'b1; code_mux3d = 5'd4;
    step();
    total++;
    if ({MUX3S, gnt_tr, gnt_rg2, gnt_mux3d, bad_code} !== 6'b00_100_1)
      $display("FAIL illegal_tr: MUX3S %0d gnt %b%b%b bad %b, required MUX3S 0 gnt_tr bad 1", MUX3S, gnt_tr, gnt_rg2, gnt_mux3d, bad_code);
    else passed++;
    req_tr = 1'b0;
    step();
    total++;
    if ({MUX3S, gnt_tr, gnt_rg2, gnt_mux3d, bad_code} !== 6'b01_001_0)
      $display("FAIL illegal_next_mux3d: MUX3S %0d gnt %b%b%b bad %b, required MUX3S 1 gnt_mux3d bad 0", MUX3S, gnt_tr, gnt_rg2, gnt_mux3d, bad_code);
    else passed++;
    req_mux3d = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    logic [4:0] exp_code;
    req_rg2 = 1'b1; code_rg2 = 5'd9;
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      exp_code = (k <= 18) ? 5'(k) : (k == 19) ? 5'd21 : 5'd22;
      total++;
      if (MUX3S !== 2'd1 || sweep_active !== 1'b1 || sweep_code !== exp_code ||
          {gnt_tr, gnt_rg2, gnt_mux3d} !== 3'b000 || busy !== 1'b1 || init_done !== 1'b0)
        $display("FAIL sweep_step %0d: MUX3S %0d active %b code %0d gnt %b%b%b busy %b done %b, required 1 1 %0d 000 1 0",
                 k, MUX3S, sweep_active, sweep_code, gnt_tr, gnt_rg2, gnt_mux3d, busy, init_done, exp_code);
      else passed++;
      step();
    end
    total++;
    if (outs() !== 14'b00_000_0_00000_1_0_0)
      $display("FAIL sweep_done: outputs %b, required only init_done", outs());
    else passed++;
    step();
    total++;
    if ({MUX3S, gnt_tr, gnt_rg2, gnt_mux3d, init_done} !== 6'b10_010_0)
      $display("FAIL sweep_then_rg2: MUX3S %0d gnt %b%b%b done %b, required MUX3S 2 gnt_rg2 done 0", MUX3S, gnt_tr, gnt_rg2, gnt_mux3d, init_done);
    else passed++;
    req_rg2 = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_sweep();
    int dones;
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    total++;
    if (sweep_code !== 5'd9) $display("FAIL midsweep_code: sweep_code %0d, required 9", sweep_code);
    else passed++;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    total++;
    if (outs() !== 14'd0) $display("FAIL midsweep_reset: outputs %b, required 0", outs());
    else passed++;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (init_done !== 1'b0 || busy !== 1'b0) dones++;
    end
    total++;
    if (dones !== 0) $display("FAIL midsweep_no_done: %0d cycles with init_done/busy, required 0", dones);
    else passed++;
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    total++;
    if ({sweep_active, sweep_code, MUX3S} !== {1'b1, 5'd1, 2'd1})
      $display("FAIL midsweep_restart: active %b code %0d MUX3S %0d, required 1 1 1", sweep_active, sweep_code, MUX3S);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_broadcast_guard();
    test_illegal_code();
    test_sweep();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wr_port_arbiter.md
# wr_port_arbiter

Shares the register-file write port between three destination-code sources and drives the `MUX3S` select of the write-enable decoder. The three sources are the control-unit immediate path (`MUX3D_out`), the `RG2` field and the `TR` field. It also runs a power-up initialisation sweep that writes every addressable register once. It sits between the control unit and the write decoder. All outputs are registered.

## Interface
Parameters:
- `GUARD_CYCLES`, default 1: idle cycles forced after a broadcast (code 31) grant. Legal range 0–3.

Ports:
- `Clock` in 1: system clock; all logic on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `req_mux3d`, `req_rg2`, `req_tr` in 1 each: write requests.
- `code_mux3d`, `code_rg2`, `code_tr` in 5 each: destination code of each source. Checked for legality only.
- `init_start` in 1: start the initialisation sweep.
- `MUX3S` out 2: decoder source select. 0 = no write, 1 = MUX3D, 2 = RG2, 3 = TR.
- `gnt_mux3d`, `gnt_rg2`, `gnt_tr` out 1 each: one-cycle grant pulses, at most one high per cycle.
- `sweep_active` out 1: high while the sweep owns the MUX3D path.
- `sweep_code` out 5: code substituted onto the MUX3D path while `sweep_active` is high.
- `init_done` out 1: one-cycle pulse when the sweep completes.
- `bad_code` out 1: one-cycle pulse when a granted request carries an illegal code.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **Legal codes:** 1–18, 21, 22, 31. Code 31 is the broadcast to all 20 targets.
- **States:** IDLE, SWEEP, GUARD.
- **IDLE:**
  - `init_start` has priority: go to SWEEP and issue no grant this cycle.
  - Otherwise round-robin among asserted requests in the order mux3d → rg2 → tr.
  - Exclude the requester granted in the previous cycle from this decision.
  - On a grant: pulse that source's `gnt` and set `MUX3S` to its select value (1/2/3).
  - If the granted code is illegal: set `MUX3S`=0 and pulse `bad_code` instead.
  - After a grant, the pointer moves to the source after the granted one, legal or not.
- **Broadcast:** granting code 31 enters GUARD for `GUARD_CYCLES` cycles. With `GUARD_CYCLES`=0, stay in IDLE.
- **GUARD:** `MUX3S`=0, no grants; requests stay pending. Return to IDLE when the counter expires.
- **SWEEP:**
  - `sweep_active`=1 and `MUX3S`=1.
  - `sweep_code` steps one per cycle: 1, 2, …, 18, 21, 22 (20 cycles).
  - No grants; `init_start` is ignored.
  - After code 22: return to IDLE, drive `MUX3S`=0 and `sweep_active`=0, and pulse `init_done` in the first IDLE cycle.
- **No request:** in IDLE with no request, `MUX3S`=0.

## Timing
- **Reset values:** on any rising edge with `Reset`=1, including mid-sweep or mid-guard:
  - state IDLE and pointer at mux3d;
  - `MUX3S`=0, all `gnt`=0, `sweep_active`=0, `sweep_code`=0;
  - `init_done`=0, `bad_code`=0, `busy`=0.
  - An aborted sweep never pulses `init_done`.
- **Request/grant handshake:**
  - `req` sampled high at edge E: `gnt` and `MUX3S` are valid in the cycle after E, called cycle G.
  - The decoder registers the select at the end of cycle G, so the write enable appears in cycle G+1.
  - The requester holds its `code` and `req` stable through cycle G and deasserts `req` in cycle G+1, unless it is issuing a new request.
  - The `req` still high during cycle G is not re-granted, because of the previous-grant exclusion.
- **Latency and throughput:** one grant per cycle maximum. A lone requester gets its grant one cycle after raising `req`. Requests held continuously from all three sources are granted in a rotating cycle, one grant per clock.
- **Sweep timing:** `init_start` sampled at edge E gives `sweep_code`=1 in cycle E+1 and `sweep_code`=22 in cycle E+20. `init_done` pulses in cycle E+21.
- **Simultaneous events:**
  - `init_start` together with requests: the sweep wins and the requests wait.
  - A broadcast grant with other requests pending: the pending requests are granted only after GUARD.

## Test plan
- **Reset/idle:** reset, then all requests low for 5 cycles → all outputs 0 and `busy`=0 throughout.
- **Round-robin:** hold `req_mux3d`, `req_rg2`, `req_tr` continuously with codes 3, 7, 16 → grants in the order mux3d, rg2, tr, mux3d… with `MUX3S` = 1, 2, 3, 1… one per cycle, and no consecutive grant to the same source.
- **Broadcast guard:** set `GUARD_CYCLES`=2, `req_rg2` with code 31, `req_tr` with code 5 pending → `gnt_rg2` with `MUX3S`=2, then two cycles of `MUX3S`=0, then `gnt_tr` with `MUX3S`=3.
- **Illegal code:** `req_tr` with code 20 → `gnt_tr`=1, `MUX3S`=0, `bad_code`=1 in the same cycle. The next grant goes to mux3d if it is requesting.
- **Sweep:** pulse `init_start` with `req_rg2` high → 20 cycles of `MUX3S`=1 with `sweep_code` 1…18, 21, 22 and no grants → `init_done` pulse → `gnt_rg2` in the following cycle.
- **Reset mid-sweep:** assert `Reset` at sweep code 9 → next cycle all outputs 0, no `init_done`, and a fresh `init_start` restarts the sweep at code 1.
